ex_hazard_ctrl: RTL and testbench

EX_HAZARD_CTRL -- requirements
Module: ex_hazard_ctrl

---
 rtl/ex_hazard_ctrl_if.sv | 50 +++++
 rtl/ex_hazard_ctrl.sv | 134 +++++++++++++
 tb/tb_ex_hazard_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and ex_hazard_ctrl.
// The master side is the pipeline: it presents register indices and status
// and consumes the forwarding selects and the stall/bubble/flush controls.
interface ex_hazard_ctrl_if #(
  parameter int INDEX = 5
);
  logic [INDEX-1:0] ifid_rs1_in;
  logic [INDEX-1:0] ifid_rs2_in;
  logic [INDEX-1:0] idex_rs1_in;
  logic [INDEX-1:0] idex_rs2_in;
  logic [INDEX-1:0] idex_rd_in;
  logic             idex_mem_read_in;
  logic [INDEX-1:0] exmem_rd_in;
  logic             exmem_reg_write_in;
  logic [INDEX-1:0] memwb_rd_in;
  logic             memwb_reg_write_in;
  logic             branch_taken_in;
  logic             mc_op_in;
  logic             mc_done_in;

  logic [1:0]       rs1_src_out;
  logic [1:0]       rs2_src_out;
  logic             pc_stall_out;
  logic             ifid_stall_out;
  logic             idex_stall_out;
  logic             idex_bubble_out;
  logic             exmem_bubble_out;
  logic             ifid_flush_out;
  logic             mc_start_out;
  logic             mc_error_out;
  logic [15:0]      stall_cnt_out;

  modport master (
    output ifid_rs1_in, ifid_rs2_in, idex_rs1_in, idex_rs2_in, idex_rd_in,
           idex_mem_read_in, exmem_rd_in, exmem_reg_write_in, memwb_rd_in,
           memwb_reg_write_in, branch_taken_in, mc_op_in, mc_done_in,
    input  rs1_src_out, rs2_src_out, pc_stall_out, ifid_stall_out,
           idex_stall_out, idex_bubble_out, exmem_bubble_out, ifid_flush_out,
           mc_start_out, mc_error_out, stall_cnt_out
  );

  modport slave (
    input  ifid_rs1_in, ifid_rs2_in, idex_rs1_in, idex_rs2_in, idex_rd_in,
           idex_mem_read_in, exmem_rd_in, exmem_reg_write_in, memwb_rd_in,
           memwb_reg_write_in, branch_taken_in, mc_op_in, mc_done_in,
    output rs1_src_out, rs2_src_out, pc_stall_out, ifid_stall_out,
           idex_stall_out, idex_bubble_out, exmem_bubble_out, ifid_flush_out,
           mc_start_out, mc_error_out, stall_cnt_out
  );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller: operand forwarding selects, load-use stall,
// taken-branch flush, and sequencing of a multicycle unit with a timeout.
module ex_hazard_ctrl #(
  parameter int INDEX      = 5,
  parameter int MC_TIMEOUT = 64
) (
  input  logic               clk_in,
  input  logic               rstn_in,
  ex_hazard_ctrl_if.slave    hz
);

  localparam int            CW       = $clog2(MC_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(MC_TIMEOUT - 1);

  if (MC_TIMEOUT < 2) begin : g_bad_timeout
    $error("ex_hazard_ctrl: MC_TIMEOUT must be at least 2");
  end

  typedef enum logic {
    ST_RUN,
    ST_MC_WAIT
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  logic [15:0]   scnt_q;

  logic pc_stall, ifid_stall, idex_stall;
  logic idex_bubble, exmem_bubble, ifid_flush, mc_start;
  logic load_use;

  // EX/MEM wins over MEM/WB because it holds the younger result.
  function automatic logic [1:0] fwd_sel(
    input logic [INDEX-1:0] rs,
    input logic [INDEX-1:0] ex_rd,
    input logic             ex_we,
    input logic [INDEX-1:0] wb_rd,
    input logic             wb_we
  );
    if (ex_we && (ex_rd != '0) && (ex_rd == rs)) return 2'b10;
    if (wb_we && (wb_rd != '0) && (wb_rd == rs)) return 2'b01;
    return 2'b00;
  endfunction

  // Forwarding is state-independent and stays live during reset.
  assign hz.rs1_src_out = fwd_sel(hz.idex_rs1_in, hz.exmem_rd_in, hz.exmem_reg_write_in,
                                  hz.memwb_rd_in, hz.memwb_reg_write_in);
  assign hz.rs2_src_out = fwd_sel(hz.idex_rs2_in, hz.exmem_rd_in, hz.exmem_reg_write_in,
                                  hz.memwb_rd_in, hz.memwb_reg_write_in);

  assign load_use = hz.idex_mem_read_in && (hz.idex_rd_in != '0) &&
                    ((hz.idex_rd_in == hz.ifid_rs1_in) || (hz.idex_rd_in == hz.ifid_rs2_in));

  // Next-state and pipeline controls; outputs are forced low while in reset.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_d      = state_q;
    tmo_d        = tmo_q;
    err_d        = err_q;
    pc_stall     = 1'b0;
    ifid_stall   = 1'b0;
    idex_stall   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    ifid_flush   = 1'b0;
    mc_start     = 1'b0;
    if (rstn_in) begin
      unique case (state_q)
        ST_RUN: begin
          if (hz.mc_op_in) begin
            mc_start     = 1'b1;
            pc_stall     = 1'b1;
            ifid_stall   = 1'b1;
            idex_stall   = 1'b1;
            exmem_bubble = 1'b1;
            tmo_d        = '0;
            state_d      = ST_MC_WAIT;
          end else if (hz.branch_taken_in) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (load_use) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_bubble = 1'b1;
          end
        end
        ST_MC_WAIT: begin
          // Done or timeout both release the pipeline so EX/MEM latches the result.
          if (hz.mc_done_in) begin
            state_d = ST_RUN;
          end else if (tmo_q == CNT_LAST) begin
            err_d   = 1'b1;
            state_d = ST_RUN;
          end else begin
            pc_stall     = 1'b1;
            ifid_stall   = 1'b1;
            idex_stall   = 1'b1;
            exmem_bubble = 1'b1;
            tmo_d        = tmo_q + 1'b1;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // State, timeout counter, sticky error and saturating stall counter.
  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      state_q <= ST_RUN;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      scnt_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so all registers see pre-edge values.
      state_q <= state_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      if (pc_stall && (scnt_q != 16'hFFFF)) scnt_q <= scnt_q + 16'd1;
    end
  end

  assign hz.pc_stall_out     = pc_stall;
  assign hz.ifid_stall_out   = ifid_stall;
  assign hz.idex_stall_out   = idex_stall;
  assign hz.idex_bubble_out  = idex_bubble;
  assign hz.exmem_bubble_out = exmem_bubble;
  assign hz.ifid_flush_out   = ifid_flush;
  assign hz.mc_start_out     = mc_start;
  assign hz.mc_error_out     = err_q;
  assign hz.stall_cnt_out    = scnt_q;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Self-checking bench for ex_hazard_ctrl: forwarding vector table, directed
// multi-cycle sequences, randomized run against a reference model, saturation.
module tb_ex_hazard_ctrl;
  localparam int IDX = 5;
  localparam int TO  = 4;

  // Control vector order: {pc_stall, ifid_stall, idex_stall, idex_bubble, exmem_bubble, ifid_flush, mc_start}
  localparam logic [6:0] C_NONE   = 7'b000_0000;
  localparam logic [6:0] C_LOAD   = 7'b110_1000;
  localparam logic [6:0] C_BRANCH = 7'b000_1010;
  localparam logic [6:0] C_START  = 7'b111_0101;
  localparam logic [6:0] C_WAIT   = 7'b111_0100;

  logic clk_in  = 1'b0;
  logic rstn_in = 1'b1;

  ex_hazard_ctrl_if #(.INDEX(IDX)) hz();

  ex_hazard_ctrl #(.INDEX(IDX), .MC_TIMEOUT(TO)) dut (
    .clk_in (clk_in),
    .rstn_in(rstn_in),
    .hz     (hz)
  );

  always #5 clk_in = ~clk_in;

  int vectors     = 0;
  int miscompares = 0;
  int exp_scnt    = 0;

  // Reference model: m_wait is -1 when running, else MC_WAIT cycles elapsed.
  int m_wait = -1;
  bit m_err  = 1'b0;
  int m_scnt = 0;

  typedef struct {
    logic [IDX-1:0] ex_rd;
    logic           ex_we;
    logic [IDX-1:0] wb_rd;
    logic           wb_we;
    logic [IDX-1:0] rs1;
    logic [IDX-1:0] rs2;
    logic [1:0]     exp1;
    logic [1:0]     exp2;
  } fwd_vec_t;

  fwd_vec_t fwd_tab[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] ctrl_vec();
    return {hz.pc_stall_out, hz.ifid_stall_out, hz.idex_stall_out, hz.idex_bubble_out,
            hz.exmem_bubble_out, hz.ifid_flush_out, hz.mc_start_out};
  endfunction

  task automatic clear_inputs();
    hz.ifid_rs1_in        = '0;
    hz.ifid_rs2_in        = '0;
    hz.idex_rs1_in        = '0;
    hz.idex_rs2_in        = '0;
    hz.idex_rd_in         = '0;
    hz.idex_mem_read_in   = 1'b0;
    hz.exmem_rd_in        = '0;
    hz.exmem_reg_write_in = 1'b0;
    hz.memwb_rd_in        = '0;
    hz.memwb_reg_write_in = 1'b0;
    hz.branch_taken_in    = 1'b0;
    hz.mc_op_in           = 1'b0;
    hz.mc_done_in         = 1'b0;
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [1:0] ref_fwd(input logic [IDX-1:0] rs);
    if (hz.exmem_reg_write_in && hz.exmem_rd_in != 0 && hz.exmem_rd_in == rs) return 2'd2;
    if (hz.memwb_reg_write_in && hz.memwb_rd_in != 0 && hz.memwb_rd_in == rs) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [6:0] ref_ctrl();
    bit lu;
    lu = hz.idex_mem_read_in && (hz.idex_rd_in != 0) &&
         ((hz.idex_rd_in == hz.ifid_rs1_in) || (hz.idex_rd_in == hz.ifid_rs2_in));
    if (m_wait < 0) begin
      if (hz.mc_op_in)        return C_START;
      if (hz.branch_taken_in) return C_BRANCH;
      if (lu)                 return C_LOAD;
      return C_NONE;
    end
    if (hz.mc_done_in || m_wait == TO - 1) return C_NONE;
    return C_WAIT;
  endfunction

  task automatic ref_commit(input logic [6:0] c);
    if (c[6] && m_scnt < 65535) m_scnt++;
    if (m_wait < 0) begin
      if (hz.mc_op_in) m_wait = 0;
    end else if (hz.mc_done_in) begin
      m_wait = -1;
    end else if (m_wait == TO - 1) begin
      m_err  = 1'b1;
      m_wait = -1;
    end else begin
      m_wait++;
    end
  endtask

  initial begin
    logic [6:0] exp_c;
    int n;

    fwd_tab[0] = '{5'd5,  1'b1, 5'd5,  1'b1, 5'd5,  5'd0,  2'd2, 2'd0};
    fwd_tab[1] = '{5'd0,  1'b1, 5'd0,  1'b1, 5'd0,  5'd0,  2'd0, 2'd0};
    fwd_tab[2] = '{5'd3,  1'b1, 5'd5,  1'b1, 5'd5,  5'd3,  2'd1, 2'd2};
    fwd_tab[3] = '{5'd5,  1'b0, 5'd5,  1'b1, 5'd5,  5'd5,  2'd1, 2'd1};
    fwd_tab[4] = '{5'd5,  1'b1, 5'd5,  1'b0, 5'd5,  5'd5,  2'd2, 2'd2};
    fwd_tab[5] = '{5'd9,  1'b1, 5'd4,  1'b1, 5'd4,  5'd9,  2'd1, 2'd2};
    fwd_tab[6] = '{5'd31, 1'b1, 5'd31, 1'b1, 5'd31, 5'd30, 2'd2, 2'd0};
    fwd_tab[7] = '{5'd6,  1'b0, 5'd6,  1'b0, 5'd6,  5'd6,  2'd0, 2'd0};
    fwd_tab[8] = '{5'd0,  1'b1, 5'd2,  1'b1, 5'd0,  5'd2,  2'd0, 2'd1};
    fwd_tab[9] = '{5'd2,  1'b1, 5'd0,  1'b1, 5'd0,  5'd0,  2'd0, 2'd0};

    // Reset: controls held low even with mc_op requested; forwarding stays live.
    clear_inputs();
    hz.mc_op_in           = 1'b1;
    hz.exmem_rd_in        = 5'd5;
    hz.exmem_reg_write_in = 1'b1;
    hz.idex_rs1_in        = 5'd5;
    #2 rstn_in = 1'b0;
    step();
    step();
    check("rst_ctrl", ctrl_vec(), C_NONE);
    check("rst_fwd", hz.rs1_src_out, 2'd2);
    check("rst_scnt", hz.stall_cnt_out, 16'd0);
    check("rst_err", hz.mc_error_out, 1'b0);
    clear_inputs();
    rstn_in = 1'b1;
    settle();
    check("run_idle", ctrl_vec(), C_NONE);

    // Forwarding table.
    for (int i = 0; i < 10; i++) begin
      hz.exmem_rd_in        = fwd_tab[i].ex_rd;
      hz.exmem_reg_write_in = fwd_tab[i].ex_we;
      hz.memwb_rd_in        = fwd_tab[i].wb_rd;
      hz.memwb_reg_write_in = fwd_tab[i].wb_we;
      hz.idex_rs1_in        = fwd_tab[i].rs1;
      hz.idex_rs2_in        = fwd_tab[i].rs2;
      settle();
      check($sformatf("fwd%0d_rs1", i), hz.rs1_src_out, fwd_tab[i].exp1);
      check($sformatf("fwd%0d_rs2", i), hz.rs2_src_out, fwd_tab[i].exp2);
    end
    clear_inputs();
    step();

    // Load-use: one stall cycle.
    hz.idex_mem_read_in = 1'b1;
    hz.idex_rd_in       = 5'd7;
    hz.ifid_rs2_in      = 5'd7;
    settle();
    check("lu_ctrl", ctrl_vec(), C_LOAD);
    step();
    clear_inputs();
    settle();
    exp_scnt += 1;
    check("lu_scnt", hz.stall_cnt_out, exp_scnt);
    check("lu_after", ctrl_vec(), C_NONE);
    step();

    // Branch beats a simultaneous load-use.
    hz.branch_taken_in  = 1'b1;
    hz.idex_mem_read_in = 1'b1;
    hz.idex_rd_in       = 5'd7;
    hz.ifid_rs1_in      = 5'd7;
    settle();
    check("br_ctrl", ctrl_vec(), C_BRANCH);
    step();
    clear_inputs();
    settle();
    check("br_scnt", hz.stall_cnt_out, exp_scnt);
    step();

    // Multicycle op, done at cycle 3; mc_op held high throughout.
    hz.mc_op_in = 1'b1;
    settle();
    check("mc_c0", ctrl_vec(), C_START);
    step();
    settle();
    check("mc_c1", ctrl_vec(), C_WAIT);
    step();
    hz.branch_taken_in  = 1'b1;
    hz.idex_mem_read_in = 1'b1;
    hz.idex_rd_in       = 5'd7;
    hz.ifid_rs1_in      = 5'd7;
    settle();
    check("mc_c2", ctrl_vec(), C_WAIT);
    step();
    clear_inputs();
    hz.mc_op_in   = 1'b1;
    hz.mc_done_in = 1'b1;
    settle();
    check("mc_c3", ctrl_vec(), C_NONE);
    step();
    clear_inputs();
    hz.branch_taken_in = 1'b1;
    settle();
    check("mc_c4_run", ctrl_vec(), C_BRANCH);
    exp_scnt += 3;
    check("mc_scnt", hz.stall_cnt_out, exp_scnt);
    step();
    clear_inputs();

    // Timeout: four MC_WAIT cycles, error sticky, next op still works.
    hz.mc_op_in = 1'b1;
    settle();
    check("to_c0", ctrl_vec(), C_START);
    step();
    hz.mc_op_in = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      settle();
      check($sformatf("to_c%0d", k), ctrl_vec(), C_WAIT);
      check($sformatf("to_err%0d", k), hz.mc_error_out, 1'b0);
      step();
    end
    settle();
    check("to_c4", ctrl_vec(), C_NONE);
    check("to_err4", hz.mc_error_out, 1'b0);
    step();
    check("to_err5", hz.mc_error_out, 1'b1);
    exp_scnt += 4;
    check("to_scnt", hz.stall_cnt_out, exp_scnt);
    hz.mc_op_in = 1'b1;
    settle();
    check("to_restart", ctrl_vec(), C_START);
    step();
    hz.mc_op_in = 1'b0;
    settle();
    check("to_rw1", ctrl_vec(), C_WAIT);
    step();
    settle();
    check("to_rw2", ctrl_vec(), C_WAIT);
    step();
    hz.mc_done_in = 1'b1;
    settle();
    check("to_rdone", ctrl_vec(), C_NONE);
    step();
    clear_inputs();
    settle();
    exp_scnt += 3;
    check("to_err_sticky", hz.mc_error_out, 1'b1);
    check("to_scnt2", hz.stall_cnt_out, exp_scnt);
    step();

    // Reset asserted in MC_WAIT drops controls with no clock edge.
    hz.mc_op_in = 1'b1;
    settle();
    check("ra_start", ctrl_vec(), C_START);
    step();
    hz.mc_op_in = 1'b0;
    settle();
    check("ra_wait", ctrl_vec(), C_WAIT);
    #2;
    rstn_in = 1'b0;
    #1;
    check("ra_ctrl", ctrl_vec(), C_NONE);
    check("ra_scnt", hz.stall_cnt_out, 16'd0);
    check("ra_err", hz.mc_error_out, 1'b0);
    hz.mc_op_in = 1'b1;
    step();
    step();
    check("ra_hold", ctrl_vec(), C_NONE);
    clear_inputs();
    rstn_in  = 1'b1;
    exp_scnt = 0;
    hz.idex_mem_read_in = 1'b1;
    hz.idex_rd_in       = 5'd3;
    hz.ifid_rs1_in      = 5'd3;
    settle();
    check("ra_run", ctrl_vec(), C_LOAD);
    step();
    clear_inputs();
    settle();
    exp_scnt = 1;
    check("ra_scnt2", hz.stall_cnt_out, exp_scnt);
    check("ra_err2", hz.mc_error_out, 1'b0);
    step();

    // Randomized run against the reference model.
    m_wait = -1;
    m_err  = 1'b0;
    m_scnt = exp_scnt;
    for (int c = 0; c < 3000; c++) begin
      hz.ifid_rs1_in        = 5'($urandom_range(0, 3));
      hz.ifid_rs2_in        = 5'($urandom_range(0, 3));
      hz.idex_rs1_in        = 5'($urandom_range(0, 3));
      hz.idex_rs2_in        = 5'($urandom_range(0, 3));
      hz.idex_rd_in         = 5'($urandom_range(0, 3));
      hz.idex_mem_read_in   = 1'($urandom_range(0, 1));
      hz.exmem_rd_in        = 5'($urandom_range(0, 3));
      hz.exmem_reg_write_in = 1'($urandom_range(0, 1));
      hz.memwb_rd_in        = 5'($urandom_range(0, 3));
      hz.memwb_reg_write_in = 1'($urandom_range(0, 1));
      hz.branch_taken_in    = ($urandom_range(0, 3) == 0);
      hz.mc_op_in           = ($urandom_range(0, 7) == 0);
      hz.mc_done_in         = ($urandom_range(0, 3) == 0);
      settle();
      exp_c = ref_ctrl();
      check("rnd_ctrl", ctrl_vec(), exp_c);
      check("rnd_rs1", hz.rs1_src_out, ref_fwd(hz.idex_rs1_in));
      check("rnd_rs2", hz.rs2_src_out, ref_fwd(hz.idex_rs2_in));
      check("rnd_scnt", hz.stall_cnt_out, m_scnt);
      check("rnd_err", hz.mc_error_out, m_err);
      ref_commit(exp_c);
      step();
    end

    // Saturation: continuous load-use stalls past 0xFFFF.
    clear_inputs();
    hz.idex_mem_read_in = 1'b1;
    hz.idex_rd_in       = 5'd9;
    hz.ifid_rs1_in      = 5'd9;
    n = 65535 - m_scnt + 8;
    for (int i = 0; i < n; i++) step();
    settle();
    check("sat_ctrl", ctrl_vec(), C_LOAD);
    check("sat_scnt", hz.stall_cnt_out, 16'hFFFF);
    step();
    check("sat_hold", hz.stall_cnt_out, 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
